derandomizer: RTL and testbench

Receive-side counterpart of the team's PRBS-15 randomizer. It removes the 1 + x^14 + x^15 scrambling from a serial bit stream, one block at a time, and recovers the original payload. A seed load starts each block; a per-block bit counter frames it. The block sits between the demodulated bit stream and the FEC decoder and uses the same seed convention and bit order as the transmit-side randomizer.

---
 rtl/derand_pkg.sv | 22 ++
 rtl/prbs15_lfsr.sv | 32 +++
 rtl/derandomizer.sv | 122 ++++++++++++
 tb/tb_derandomizer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/derand_pkg.sv
// Shared constants and types for the PRBS-15 (1 + x^14 + x^15) derandomizer.
// Seed convention: seed[14] is r1, seed[0] is r15.
// Tap positions are numbered r1..r15 as in the polynomial.
package derand_pkg;

    localparam int SEED_W = 15;
    localparam int TAP_A  = 14;
    localparam int TAP_B  = 15;

    localparam logic [SEED_W-1:0] DEFAULT_SEED = 15'b011_0111_0001_0101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Vector index of register stage r<n>; r1 sits at the MSB.
    function automatic int tap_idx(input int n);
        return SEED_W - n;
    endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// PRBS-15 Fibonacci LFSR shared by the randomizer and the derandomizer.
// Latency: o_f is combinational from the current state; load and advance act on the next edge.
// Backpressure: none; the state moves only when i_adv is high, and load has priority.
module prbs15_lfsr
    import derand_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [SEED_W-1:0] i_seed,
    input  logic              i_adv,
    output logic              o_f
);

    logic [SEED_W-1:0] r_lfsr;
    logic              w_f;

    assign w_f = r_lfsr[tap_idx(TAP_A)] ^ r_lfsr[tap_idx(TAP_B)];
    assign o_f = w_f;

    // Seed load wins over advance; an advance shifts r1..r14 down and feeds f into r1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= '0;
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_adv) begin
            r_lfsr <= {w_f, r_lfsr[SEED_W-1:1]};
        end
    end

endmodule

// File: rtl/derandomizer.sv
// Block-framed PRBS-15 derandomizer: out_bit = in_bit ^ (r14 ^ r15) per accepted bit.
// Latency: 1 cycle from accepting edge to out_valid/out_bit/block_done/drop_err.
// Backpressure: none; bits arriving while IDLE or alongside a load are dropped with drop_err.
// Option: define DERAND_AUTO_RELOAD_EN to reload the stored seed at block end and stay in RUN.
module derandomizer
    import derand_pkg::*;
#(
    parameter int BLOCK_BITS = 96
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [SEED_W-1:0] i_seed,
    input  logic              i_in_valid,
    input  logic              i_in_bit,
    output logic              o_out_valid,
    output logic              o_out_bit,
    output logic              o_block_done,
    output logic              o_busy,
    output logic              o_drop_err
);

    localparam int CNT_W = $clog2(BLOCK_BITS + 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEED_W-1:0] r_seed;
    logic              r_busy;
    logic              r_out_valid;
    logic              r_out_bit;
    logic              r_block_done;
    logic              r_drop_err;

    logic              w_accept;
    logic              w_last;
    logic              w_reload;
    logic              w_lfsr_load;
    logic [SEED_W-1:0] w_lfsr_seed;
    logic              w_f;

    // A load in the same cycle steals the bit: the block restarts and the bit is dropped.
    assign w_accept = (r_state == RUN) && i_in_valid && !i_load;
    assign w_last   = w_accept && (r_cnt == CNT_W'(BLOCK_BITS - 1));

`ifdef DERAND_AUTO_RELOAD_EN
    assign w_reload = w_last;
`else
    assign w_reload = 1'b0;
`endif

    assign w_lfsr_load = i_load || w_reload;
    assign w_lfsr_seed = i_load ? i_seed : r_seed;

    prbs15_lfsr u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_lfsr_load),
        .i_seed  (w_lfsr_seed),
        .i_adv   (w_accept),
        .o_f     (w_f)
    );

    // Block FSM, bit counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_seed       <= '0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_bit    <= 1'b0;
            r_block_done <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_out_valid  <= w_accept;
            r_block_done <= w_last;
            r_drop_err   <= i_in_valid && !w_accept;
            if (w_accept) begin
                r_out_bit <= i_in_bit ^ w_f;
            end

            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_seed  <= i_seed;
                    end
                end
                RUN: begin
                    if (i_load) begin
                        // Abort: restart the block without a block_done.
                        r_cnt  <= '0;
                        r_seed <= i_seed;
                    end else if (w_last) begin
`ifdef DERAND_AUTO_RELOAD_EN
                        r_cnt   <= '0;
`else
                        r_cnt   <= CNT_W'(BLOCK_BITS);
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_bit    = r_out_bit;
    assign o_block_done = r_block_done;
    assign o_busy       = r_busy;
    assign o_drop_err   = r_drop_err;

endmodule

// File: tb/tb_derandomizer.sv
// Self-checking bench for derandomizer with a sequence-recurrence reference model.
// Inputs driven on the falling edge, outputs sampled on the following falling edge.
// Build with DERAND_AUTO_RELOAD_EN defined to exercise the auto-reload variant.
module tb_derandomizer;
    import derand_pkg::*;

    localparam int          BB       = 96;
    localparam logic [95:0] STREAM   = 96'h558AC4A53A1724E163AC2BF9;
    localparam logic [95:0] EXP_OUT  = 96'hACBCD2114DAE1577C6DBF4C9;
`ifdef DERAND_AUTO_RELOAD_EN
    localparam logic        AUTO     = 1'b1;
`else
    localparam logic        AUTO     = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              i_load;
    logic [SEED_W-1:0] i_seed;
    logic              i_in_valid;
    logic              i_in_bit;
    logic              o_out_valid;
    logic              o_out_bit;
    logic              o_block_done;
    logic              o_busy;
    logic              o_drop_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic s_ov, s_ob, s_bd, s_busy, s_de;

    derandomizer #(.BLOCK_BITS(BB)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load       (i_load),
        .i_seed       (i_seed),
        .i_in_valid   (i_in_valid),
        .i_in_bit     (i_in_bit),
        .o_out_valid  (o_out_valid),
        .o_out_bit    (o_out_bit),
        .o_block_done (o_block_done),
        .o_busy       (o_busy),
        .o_drop_err   (o_drop_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Keystream as a bit sequence: a[0..14] = r15..r1 of the seed, a[n+15] = a[n+1] ^ a[n],
    // and bit n of the block is unscrambled with a[n+15].
    function automatic logic [95:0] model_descramble(input logic [14:0] seed, input logic [95:0] data);
        bit          a[$];
        logic [95:0] r;
        bit          k;
        r = '0;
        for (int j = 0; j < 15; j++) a.push_back(seed[j]);
        for (int n = 0; n < 96; n++) begin
            k = a[n+1] ^ a[n];
            a.push_back(k);
            r[95-n] = data[95-n] ^ k;
        end
        return r;
    endfunction

    // One clock: drive at falling edge, sample the registered response at the next falling edge.
    task automatic step(input logic ld, input logic [14:0] sd, input logic v, input logic b);
        i_load     = ld;
        i_seed     = sd;
        i_in_valid = v;
        i_in_bit   = b;
        @(posedge clk);
        @(negedge clk);
        s_ov   = o_out_valid;
        s_ob   = o_out_bit;
        s_bd   = o_block_done;
        s_busy = o_busy;
        s_de   = o_drop_err;
        i_load     = 1'b0;
        i_in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends n bits of data (MSB first) while RUN, with random idle cycles; gathers the response.
    task automatic send_stream(input logic [95:0] data, input int n, input int gap_pct,
                               output logic [95:0] got, output int nv, output int nd,
                               output int done_idx, output int nbad, output logic last_busy,
                               output logic min_busy);
        int acc;
        int cyc;
        logic v;
        logic b;
        got = '0; nv = 0; nd = 0; done_idx = -1; nbad = 0; acc = 0; cyc = 0;
        last_busy = 1'b0; min_busy = 1'b1;
        while (acc < n && cyc < n * 20 + 100) begin
            v = ($urandom_range(99) >= gap_pct);
            b = v ? data[95-acc] : 1'($urandom_range(1));
            step(1'b0, '0, v, b);
            cyc++;
            if (s_ov !== v || s_de !== 1'b0 || (s_bd === 1'b1 && s_ov !== 1'b1)) nbad++;
            if (s_ov === 1'b1) begin
                got = {got[94:0], s_ob};
                nv++;
            end
            if (s_bd === 1'b1) begin
                nd++;
                done_idx = acc;
            end
            if (v) acc++;
            last_busy = s_busy;
            min_busy  = min_busy & s_busy;
        end
        if (acc < n) nbad++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_load = 1'b0; i_seed = '0; i_in_valid = 1'b0; i_in_bit = 1'b0;
        #1;
        tests_run++;
        if ({o_out_valid, o_out_bit, o_block_done, o_busy, o_drop_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {o_out_valid, o_out_bit, o_block_done, o_busy, o_drop_err});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy_after_release: got %b want 0", o_busy);
        end
    endtask

    task automatic test_nominal();
        logic [95:0] got; int nv, nd, di, nbad; logic lb, mb;
        step(1'b1, DEFAULT_SEED, 1'b0, 1'b0);
        tests_run++;
        if (s_busy !== 1'b1 || s_ov !== 1'b0) begin
            tests_failed++;
            $display("FAIL nominal_load: busy=%b ov=%b want busy=1 ov=0", s_busy, s_ov);
        end
        send_stream(STREAM, BB, 0, got, nv, nd, di, nbad, lb, mb);
        tests_run++;
        if (got !== EXP_OUT) begin
            tests_failed++;
            $display("FAIL nominal_data: got %h want %h", got, EXP_OUT);
        end
        tests_run++;
        if (got !== model_descramble(DEFAULT_SEED, STREAM)) begin
            tests_failed++;
            $display("FAIL nominal_model: got %h want %h", got, model_descramble(DEFAULT_SEED, STREAM));
        end
        tests_run++;
        if (nv != BB || nd != 1 || di != BB - 1 || nbad != 0) begin
            tests_failed++;
            $display("FAIL nominal_framing: nv=%0d nd=%0d done_idx=%0d bad=%0d want %0d 1 %0d 0",
                     nv, nd, di, nbad, BB, BB - 1);
        end
        tests_run++;
        if (lb !== AUTO) begin
            tests_failed++;
            $display("FAIL nominal_busy_end: got %b want %b", lb, AUTO);
        end
    endtask

    task automatic test_gapped();
        logic [95:0] got; int nv, nd, di, nbad; logic lb, mb;
        step(1'b1, DEFAULT_SEED, 1'b0, 1'b0);
        send_stream(STREAM, BB, 30, got, nv, nd, di, nbad, lb, mb);
        tests_run++;
        if (got !== EXP_OUT) begin
            tests_failed++;
            $display("FAIL gapped_data: got %h want %h", got, EXP_OUT);
        end
        tests_run++;
        if (nv != BB || nd != 1 || di != BB - 1 || nbad != 0) begin
            tests_failed++;
            $display("FAIL gapped_timing: nv=%0d nd=%0d done_idx=%0d bad=%0d want %0d 1 %0d 0",
                     nv, nd, di, nbad, BB, BB - 1);
        end
    endtask

    task automatic test_mid_load();
        logic [95:0] got; int nv, nd, di, nbad; logic lb, mb;
        logic [95:0] exp_full;
        exp_full = model_descramble(DEFAULT_SEED, STREAM);
        step(1'b1, DEFAULT_SEED, 1'b0, 1'b0);
        send_stream(STREAM, 40, 20, got, nv, nd, di, nbad, lb, mb);
        tests_run++;
        if (got[39:0] !== exp_full[95:56] || nd != 0 || nbad != 0) begin
            tests_failed++;
            $display("FAIL midload_partial: got %h nd=%0d bad=%0d want %h nd=0 bad=0",
                     got[39:0], nd, nbad, exp_full[95:56]);
        end
        step(1'b1, DEFAULT_SEED, 1'b0, 1'b0);
        tests_run++;
        if (s_bd !== 1'b0 || s_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midload_abort: block_done=%b busy=%b want 0 1", s_bd, s_busy);
        end
        send_stream(STREAM, BB, 20, got, nv, nd, di, nbad, lb, mb);
        tests_run++;
        if (got !== EXP_OUT || nd != 1 || nbad != 0) begin
            tests_failed++;
            $display("FAIL midload_block: got %h nd=%0d bad=%0d want %h nd=1 bad=0",
                     got, nd, nbad, EXP_OUT);
        end
    endtask

    task automatic test_reset_mid();
        logic [95:0] got; int nv, nd, di, nbad; logic lb, mb;
        step(1'b1, DEFAULT_SEED, 1'b0, 1'b0);
        send_stream(STREAM, 50, 0, got, nv, nd, di, nbad, lb, mb);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_out_valid, o_out_bit, o_block_done, o_busy, o_drop_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL resetmid_outputs: got %b want 00000",
                     {o_out_valid, o_out_bit, o_block_done, o_busy, o_drop_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1, 1'b1);
        tests_run++;
        if (s_de !== 1'b1 || s_ov !== 1'b0 || s_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL resetmid_drop: de=%b ov=%b busy=%b want 1 0 0", s_de, s_ov, s_busy);
        end
        step(1'b1, DEFAULT_SEED, 1'b0, 1'b0);
        send_stream(STREAM, BB, 10, got, nv, nd, di, nbad, lb, mb);
        tests_run++;
        if (got !== EXP_OUT || nd != 1 || nbad != 0) begin
            tests_failed++;
            $display("FAIL resetmid_reblock: got %h nd=%0d bad=%0d want %h nd=1 bad=0",
                     got, nd, nbad, EXP_OUT);
        end
    endtask

    task automatic test_drops();
        logic [95:0] got; int nv, nd, di, nbad; logic lb, mb;
        apply_reset();
        step(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (s_de !== 1'b1 || s_ov !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_drop: de=%b ov=%b want 1 0", s_de, s_ov);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (s_de !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_drop_pulse: de=%b want 0", s_de);
        end
        step(1'b1, DEFAULT_SEED, 1'b1, 1'b1);
        tests_run++;
        if (s_de !== 1'b1 || s_ov !== 1'b0 || s_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_drop: de=%b ov=%b busy=%b want 1 0 1", s_de, s_ov, s_busy);
        end
        send_stream(STREAM, BB, 0, got, nv, nd, di, nbad, lb, mb);
        tests_run++;
        if (got !== EXP_OUT || nd != 1) begin
            tests_failed++;
            $display("FAIL collision_block: got %h nd=%0d want %h nd=1", got, nd, EXP_OUT);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        tests_run++;
        if (s_de !== ~AUTO || s_ov !== AUTO) begin
            tests_failed++;
            $display("FAIL after_block_bit: de=%b ov=%b want %b %b", s_de, s_ov, ~AUTO, AUTO);
        end
    endtask

    task automatic test_random_seeds();
        logic [95:0] got; int nv, nd, di, nbad; logic lb, mb;
        logic [14:0] sd;
        logic [95:0] data;
        for (int t = 0; t < 6; t++) begin
            apply_reset();
            sd   = 15'($urandom_range(1, 32767));
            data = {$urandom(), $urandom(), $urandom()};
            step(1'b1, sd, 1'b0, 1'b0);
            send_stream(data, BB, 25, got, nv, nd, di, nbad, lb, mb);
            tests_run++;
            if (got !== model_descramble(sd, data) || nd != 1 || nbad != 0) begin
                tests_failed++;
                $display("FAIL random_seed_%0d: seed=%h got %h nd=%0d bad=%0d want %h nd=1 bad=0",
                         t, sd, got, nd, nbad, model_descramble(sd, data));
            end
        end
    endtask

`ifdef DERAND_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [95:0] got1, got2; int nv1, nd1, di1, nb1, nv2, nd2, di2, nb2;
        logic lb1, mb1, lb2, mb2;
        apply_reset();
        step(1'b1, DEFAULT_SEED, 1'b0, 1'b0);
        send_stream(STREAM, BB, 0, got1, nv1, nd1, di1, nb1, lb1, mb1);
        send_stream(STREAM, BB, 0, got2, nv2, nd2, di2, nb2, lb2, mb2);
        tests_run++;
        if (got1 !== EXP_OUT || got2 !== EXP_OUT) begin
            tests_failed++;
            $display("FAIL auto_data: got %h %h want %h", got1, got2, EXP_OUT);
        end
        tests_run++;
        if (nd1 + nd2 != 2 || di1 != BB - 1 || di2 != BB - 1 || nb1 + nb2 != 0) begin
            tests_failed++;
            $display("FAIL auto_done: nd=%0d idx=%0d,%0d bad=%0d want 2 %0d,%0d 0",
                     nd1 + nd2, di1, di2, nb1 + nb2, BB - 1, BB - 1);
        end
        tests_run++;
        if ((mb1 & mb2) !== 1'b1) begin
            tests_failed++;
            $display("FAIL auto_busy: min busy %b want 1", mb1 & mb2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_mid_load();
        test_reset_mid();
        test_drops();
        test_random_seeds();
`ifdef DERAND_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
